memory_island_port_cut: RTL and testbench

- Per-port pipeline cut on the memory-island mem protocol (req/gnt/addr/we/wdata/strb, rvalid/rdata).
- Sits between one AXI-to-mem converter output and one memory_island_core narrow or wide requestor input.
- Breaks the combinational gnt path with a 2-entry skid buffer and optionally registers the response path.
- Bounds in-flight requests with a credit counter so the converter's response buffer can never overflow.

---
 rtl/memory_island_pkg.sv | 21 ++
 rtl/memory_island_skid_fifo.sv | 55 +++++
 rtl/memory_island_port_cut.sv | 141 ++++++++++++++
 tb/tb_memory_island_port_cut.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_island_pkg.sv
// Shared types and helpers for the memory-island port cut.
package memory_island_pkg;

  localparam int unsigned DefAddrWidth = 32;
  localparam int unsigned DefDataWidth = 64;
  localparam int unsigned DefStrbWidth = DefDataWidth / 8;

  // Request payload carried through the skid buffer at default widths.
  typedef struct packed {
    logic [DefAddrWidth-1:0] addr;
    logic                    we;
    logic [DefDataWidth-1:0] wdata;
    logic [DefStrbWidth-1:0] strb;
  } mem_req_t;

  // Width needed to count 0..max_outstanding inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

endpackage

// File: rtl/memory_island_skid_fifo.sv
// Two-entry FIFO used as the skid buffer of the port cut.
// Push is ignored when full and pop is ignored when empty.
module memory_island_skid_fifo #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  logic [1:0] cnt_q, cnt_d;
  logic       wr_ptr_q, rd_ptr_q;
  T           mem_q [2];
  logic       push_ok, pop_ok;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Occupancy: simultaneous push and pop leaves it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
      end
      wr_ptr_q <= wr_ptr_q ^ push_ok;
      rd_ptr_q <= rd_ptr_q ^ pop_ok;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/memory_island_port_cut.sv
// Per-port pipeline cut on the memory-island mem protocol: skid-buffered
// request path, credit-bounded issue, optional response register and a
// sticky error flag for unmatched responses.
module memory_island_port_cut
  import memory_island_pkg::*;
#(
  parameter int unsigned AddrWidth      = DefAddrWidth,
  parameter int unsigned DataWidth      = DefDataWidth,
  parameter int unsigned StrbWidth      = DataWidth / 8,
  parameter int unsigned MaxOutstanding = 4,
  parameter bit          CutRsp         = 1'b1,
  parameter int unsigned CntWidth       = cnt_width(MaxOutstanding)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 s_req_i,
  output logic                 s_gnt_o,
  input  logic [AddrWidth-1:0] s_addr_i,
  input  logic                 s_we_i,
  input  logic [DataWidth-1:0] s_wdata_i,
  input  logic [StrbWidth-1:0] s_strb_i,
  output logic                 s_rvalid_o,
  output logic [DataWidth-1:0] s_rdata_o,
  output logic                 m_req_o,
  input  logic                 m_gnt_i,
  output logic [AddrWidth-1:0] m_addr_o,
  output logic                 m_we_o,
  output logic [DataWidth-1:0] m_wdata_o,
  output logic [StrbWidth-1:0] m_strb_o,
  input  logic                 m_rvalid_i,
  input  logic [DataWidth-1:0] m_rdata_i,
  output logic [CntWidth-1:0]  outstanding_o,
  output logic                 busy_o,
  output logic                 err_o
);

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 we;
    logic [DataWidth-1:0] wdata;
    logic [StrbWidth-1:0] strb;
  } req_t;

  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

  req_t                in_req, head_req;
  logic                fifo_full, fifo_empty;
  logic                push, issue, rsp_matched;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;

  // ---------------------------------------------------------------------------
  // Request path
  // ---------------------------------------------------------------------------
  assign in_req = '{addr: s_addr_i, we: s_we_i, wdata: s_wdata_i, strb: s_strb_i};

  // Grant only looks at buffer state, so m_gnt_i never reaches s_gnt_o.
  assign s_gnt_o = ~fifo_full;
  assign push    = s_req_i & s_gnt_o;
  assign m_req_o = ~fifo_empty & (cnt_q < MaxCnt);
  assign issue   = m_req_o & m_gnt_i;

  memory_island_skid_fifo #(
    .T (req_t)
  ) i_skid (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (in_req),
    .pop_i   (issue),
    .data_o  (head_req),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign m_addr_o  = head_req.addr;
  assign m_we_o    = head_req.we;
  assign m_wdata_o = head_req.wdata;
  assign m_strb_o  = head_req.strb;

  // ---------------------------------------------------------------------------
  // Credit counter and error flag
  // ---------------------------------------------------------------------------
  // A response only returns a credit when one is outstanding; an unmatched
  // response in the same cycle as an issue therefore still counts the issue.
  assign rsp_matched = m_rvalid_i & (cnt_q != '0);

  // Next count and sticky error.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({issue, rsp_matched})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    err_d = err_q | (m_rvalid_i & (cnt_q == '0));
  end

  // Credit and error state registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign outstanding_o = cnt_q;
  assign err_o         = err_q;
  assign busy_o        = ~fifo_empty | (cnt_q != '0);

  // ---------------------------------------------------------------------------
  // Response path
  // ---------------------------------------------------------------------------
  if (CutRsp) begin : g_rsp_cut
    logic                 rvalid_q;
    logic [DataWidth-1:0] rdata_q;

    // One-cycle response register; data holds between responses.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        rvalid_q <= 1'b0;
        rdata_q  <= '0;
      end else begin
        rvalid_q <= m_rvalid_i;
        if (m_rvalid_i) begin
          rdata_q <= m_rdata_i;
        end
      end
    end

    assign s_rvalid_o = rvalid_q;
    assign s_rdata_o  = rdata_q;
  end else begin : g_rsp_bypass
    assign s_rvalid_o = m_rvalid_i;
    assign s_rdata_o  = m_rdata_i;
  end

endmodule

// File: tb/tb_memory_island_port_cut.sv
// Directed self-checking bench for memory_island_port_cut (default widths,
// MaxOutstanding=4, registered response path).
module tb_memory_island_port_cut;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned SW = 8;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          s_req_i;
  logic          s_gnt_o;
  logic [AW-1:0] s_addr_i;
  logic          s_we_i;
  logic [DW-1:0] s_wdata_i;
  logic [SW-1:0] s_strb_i;
  logic          s_rvalid_o;
  logic [DW-1:0] s_rdata_o;
  logic          m_req_o;
  logic          m_gnt_i;
  logic [AW-1:0] m_addr_o;
  logic          m_we_o;
  logic [DW-1:0] m_wdata_o;
  logic [SW-1:0] m_strb_o;
  logic          m_rvalid_i;
  logic [DW-1:0] m_rdata_i;
  logic [CW-1:0] outstanding_o;
  logic          busy_o;
  logic          err_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  memory_island_port_cut #(
    .AddrWidth      (AW),
    .DataWidth      (DW),
    .MaxOutstanding (4),
    .CutRsp         (1'b1)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .s_req_i       (s_req_i),
    .s_gnt_o       (s_gnt_o),
    .s_addr_i      (s_addr_i),
    .s_we_i        (s_we_i),
    .s_wdata_i     (s_wdata_i),
    .s_strb_i      (s_strb_i),
    .s_rvalid_o    (s_rvalid_o),
    .s_rdata_o     (s_rdata_o),
    .m_req_o       (m_req_o),
    .m_gnt_i       (m_gnt_i),
    .m_addr_o      (m_addr_o),
    .m_we_o        (m_we_o),
    .m_wdata_o     (m_wdata_o),
    .m_strb_o      (m_strb_o),
    .m_rvalid_i    (m_rvalid_i),
    .m_rdata_i     (m_rdata_i),
    .outstanding_o (outstanding_o),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  // Grant everything, answer every outstanding request, until idle.
  task automatic drain();
    int cyc;
    cyc = 0;
    s_req_i = 1'b0;
    m_gnt_i = 1'b1;
    while (busy_o && cyc < 40) begin
      m_rvalid_i = (outstanding_o != '0);
      tick();
      cyc++;
    end
    m_rvalid_i = 1'b0;
    settle();
    check("drain_idle", {63'd0, busy_o}, 64'd0);
  endtask

  int acc, hs, np;
  logic [AW-1:0] popped [3];

  initial begin
    rst_ni     = 1'b0;
    s_req_i    = 1'b0;
    s_addr_i   = '0;
    s_we_i     = 1'b0;
    s_wdata_i  = '0;
    s_strb_i   = '0;
    m_gnt_i    = 1'b0;
    m_rvalid_i = 1'b0;
    m_rdata_i  = '0;

    // ---------------- reset then idle ----------------
    tick();
    tick();
    check("rst_s_gnt",   {63'd0, s_gnt_o}, 64'd1);
    check("rst_m_req",   {63'd0, m_req_o}, 64'd0);
    check("rst_outst",   {61'd0, outstanding_o}, 64'd0);
    check("rst_busy",    {63'd0, busy_o}, 64'd0);
    check("rst_err",     {63'd0, err_o}, 64'd0);
    check("rst_rvalid",  {63'd0, s_rvalid_o}, 64'd0);
    check("rst_rdata",   s_rdata_o, 64'd0);
    check("rst_m_addr",  {32'd0, m_addr_o}, 64'd0);
    rst_ni = 1'b1;
    tick();
    check("idle_s_gnt",  {63'd0, s_gnt_o}, 64'd1);
    check("idle_busy",   {63'd0, busy_o}, 64'd0);

    // ---------------- single read ----------------
    m_gnt_i  = 1'b1;
    s_req_i  = 1'b1;
    s_addr_i = 32'h100;
    settle();
    check("rd_m_req_pre", {63'd0, m_req_o}, 64'd0);
    tick();
    s_req_i = 1'b0;
    settle();
    check("rd_m_req",    {63'd0, m_req_o}, 64'd1);
    check("rd_m_addr",   {32'd0, m_addr_o}, 64'h100);
    check("rd_m_we",     {63'd0, m_we_o}, 64'd0);
    check("rd_outst0",   {61'd0, outstanding_o}, 64'd0);
    tick();
    check("rd_outst1",   {61'd0, outstanding_o}, 64'd1);
    check("rd_m_req_lo", {63'd0, m_req_o}, 64'd0);
    tick();
    m_rvalid_i = 1'b1;
    m_rdata_i  = 64'hDEADBEEF;
    settle();
    check("rd_rvalid_pre", {63'd0, s_rvalid_o}, 64'd0);
    tick();
    m_rvalid_i = 1'b0;
    m_rdata_i  = 64'h5555;
    settle();
    check("rd_rvalid",   {63'd0, s_rvalid_o}, 64'd1);
    check("rd_rdata",    s_rdata_o, 64'hDEADBEEF);
    check("rd_outst_end", {61'd0, outstanding_o}, 64'd0);
    tick();
    check("rd_rvalid_lo", {63'd0, s_rvalid_o}, 64'd0);
    check("rd_rdata_hold", s_rdata_o, 64'hDEADBEEF);
    check("rd_busy_end", {63'd0, busy_o}, 64'd0);

    // ---------------- credit limit ----------------
    acc = 0;
    hs  = 0;
    m_gnt_i = 1'b1;
    for (int c = 0; c < 30 && acc < 6; c++) begin
      s_req_i  = 1'b1;
      s_addr_i = AW'(acc * 8);
      settle();
      if (s_gnt_o) acc++;
      if (m_req_o && m_gnt_i) hs++;
      tick();
    end
    s_req_i = 1'b0;
    settle();
    check("cr_accepts",  64'(acc), 64'd6);
    check("cr_hs4",      64'(hs), 64'd4);
    check("cr_s_gnt",    {63'd0, s_gnt_o}, 64'd0);
    check("cr_m_req",    {63'd0, m_req_o}, 64'd0);
    check("cr_outst",    {61'd0, outstanding_o}, 64'd4);
    for (int c = 0; c < 3; c++) begin
      if (m_req_o && m_gnt_i) hs++;
      tick();
    end
    check("cr_hs_hold",  64'(hs), 64'd4);
    m_rvalid_i = 1'b1;
    settle();
    if (m_req_o && m_gnt_i) hs++;
    tick();
    m_rvalid_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      settle();
      if (m_req_o && m_gnt_i) hs++;
      tick();
    end
    check("cr_hs5",      64'(hs), 64'd5);
    check("cr_outst2",   {61'd0, outstanding_o}, 64'd4);
    check("cr_head",     {32'd0, m_addr_o}, 64'h28);
    check("cr_s_gnt2",   {63'd0, s_gnt_o}, 64'd1);
    drain();
    check("cr_err",      {63'd0, err_o}, 64'd0);

    // ---------------- backpressure ----------------
    acc = 0;
    m_gnt_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      s_req_i  = 1'b1;
      s_addr_i = AW'(acc * 8);
      settle();
      if (s_gnt_o) acc++;
      if (m_req_o) check("bp_addr_stable", {32'd0, m_addr_o}, 64'h0);
      tick();
    end
    check("bp_accepts",  64'(acc), 64'd2);
    check("bp_s_gnt",    {63'd0, s_gnt_o}, 64'd0);
    np = 0;
    m_gnt_i = 1'b1;
    for (int c = 0; c < 20 && np < 3; c++) begin
      s_req_i  = (acc < 3);
      s_addr_i = AW'(acc * 8);
      settle();
      if (s_req_i && s_gnt_o) acc++;
      if (m_req_o && m_gnt_i) begin
        popped[np] = m_addr_o;
        np++;
      end
      tick();
    end
    s_req_i = 1'b0;
    check("bp_npop",     64'(np), 64'd3);
    check("bp_pop0",     {32'd0, popped[0]}, 64'h0);
    check("bp_pop1",     {32'd0, popped[1]}, 64'h8);
    check("bp_pop2",     {32'd0, popped[2]}, 64'h10);
    drain();

    // ---------------- simultaneous issue and response ----------------
    m_gnt_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      s_req_i  = 1'b1;
      s_addr_i = AW'(32'h200 + c * 8);
      tick();
    end
    s_req_i    = 1'b0;
    m_rvalid_i = 1'b1;
    m_rdata_i  = 64'hA5A5;
    settle();
    check("sim_outst_pre", {61'd0, outstanding_o}, 64'd2);
    check("sim_m_req",   {63'd0, m_req_o}, 64'd1);
    tick();
    m_rvalid_i = 1'b0;
    settle();
    check("sim_outst",   {61'd0, outstanding_o}, 64'd2);
    check("sim_rdata",   s_rdata_o, 64'hA5A5);
    drain();

    // ---------------- spurious response ----------------
    m_rvalid_i = 1'b1;
    m_rdata_i  = 64'h1234;
    tick();
    m_rvalid_i = 1'b0;
    settle();
    check("sp_err",      {63'd0, err_o}, 64'd1);
    check("sp_outst",    {61'd0, outstanding_o}, 64'd0);
    check("sp_rvalid",   {63'd0, s_rvalid_o}, 64'd1);
    check("sp_rdata",    s_rdata_o, 64'h1234);
    tick();
    tick();
    check("sp_err_sticky", {63'd0, err_o}, 64'd1);
    rst_ni = 1'b0;
    tick();
    check("sp_err_rst",  {63'd0, err_o}, 64'd0);
    check("sp_rdata_rst", s_rdata_o, 64'd0);
    check("sp_gnt_rst",  {63'd0, s_gnt_o}, 64'd1);
    rst_ni = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
